ram_stream_loader: RTL

- Upstream feeder for the SRAM bus controller (ram); replaces compile-time `include` preloading with runtime loading.
- Consumes a byte stream from a UART receiver: 8-byte header (start word address, word count), then payload.
- Packs the payload into 32-bit little-endian words and issues one bus write per word, waiting for ack.
- Reports progress, completion and ack-timeout error.

---
 rtl/loader_pkg.sv | 18 +
 rtl/ram_stream_loader_if.sv | 37 +++
 rtl/byte_packer.sv | 42 ++++
 rtl/ram_stream_loader.sv | 164 ++++++++++++++++
 4 files changed

// File: rtl/loader_pkg.sv
// Shared definitions for the RAM stream loader: FSM encoding and header framing constants.
package loader_pkg;

  // Loader phases: two header fields, payload assembly, bus write, and the two resting states.
  typedef enum logic [2:0] {
    HDR_ADDR = 3'd0,
    HDR_CNT  = 3'd1,
    PAYLOAD  = 3'd2,
    WRITE    = 3'd3,
    DONE     = 3'd4,
    ERROR    = 3'd5
  } loader_state_e;

  // Every field on the stream (address, count, payload word) is four bytes wide.
  localparam int HDR_BYTES  = 4;
  localparam int BYTE_IDX_W = 2;

endpackage

// File: rtl/ram_stream_loader_if.sv
// Byte-stream input and SRAM-controller write bus of the loader, bundled together.
// The master modport is the loader's view; the slave modport is the UART/RAM side.
interface ram_stream_loader_if;

  logic [7:0]  in_data;
  logic        in_valid;
  logic        in_ready;

  logic [31:0] bus_addr_o;
  logic [31:0] bus_data_o;
  logic        bus_ce_o;
  logic        bus_we_o;
  logic        bus_ack_i;

  modport master (
    input  in_data,
    input  in_valid,
    output in_ready,
    output bus_addr_o,
    output bus_data_o,
    output bus_ce_o,
    output bus_we_o,
    input  bus_ack_i
  );

  modport slave (
    output in_data,
    output in_valid,
    input  in_ready,
    input  bus_addr_o,
    input  bus_data_o,
    input  bus_ce_o,
    input  bus_we_o,
    output bus_ack_i
  );

endinterface

// File: rtl/byte_packer.sv
// Little-endian 4-byte assembler. The first three bytes are stored; on the fourth byte
// the full word is presented combinationally together with a one-cycle word_valid, so
// the owner can capture it on the same edge the last byte is accepted. The index then
// wraps to zero, ready for the next field.
module byte_packer
  import loader_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        clear,
  input  logic        byte_en,
  input  logic [7:0]  byte_in,
  output logic [31:0] word,
  output logic        word_valid
);

  logic [BYTE_IDX_W-1:0] idx_q;
  logic [23:0]           low_bytes_q;

  // Store bytes 0..2 at their little-endian lane and advance the index on every accepted byte.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      idx_q       <= '0;
      low_bytes_q <= '0;
    end else if (clear) begin
      idx_q       <= '0;
      low_bytes_q <= '0;
    end else if (byte_en) begin
      case (idx_q)
        2'd0:    low_bytes_q[7:0]   <= byte_in;
        2'd1:    low_bytes_q[15:8]  <= byte_in;
        2'd2:    low_bytes_q[23:16] <= byte_in;
        default: low_bytes_q        <= low_bytes_q;
      endcase
      idx_q <= idx_q + 1'b1;
    end
  end

  assign word       = {byte_in, low_bytes_q};
  assign word_valid = byte_en && (idx_q == BYTE_IDX_W'(HDR_BYTES - 1));

endmodule

// File: rtl/ram_stream_loader.sv
// Runtime RAM loader: parses an 8-byte header (start word address, word count) from a
// byte stream, packs the payload into 32-bit little-endian words and writes each one to
// the SRAM controller, waiting for ack with a bounded timeout.
module ram_stream_loader
  import loader_pkg::*;
#(
  parameter int ADDR_W      = 20,
  parameter int ACK_TIMEOUT = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 abort,
  ram_stream_loader_if.master  bus,
  output logic                 busy,
  output logic                 done,
  output logic                 error,
  output logic [31:0]          words_written
);

  localparam int WAIT_W = (ACK_TIMEOUT > 1) ? $clog2(ACK_TIMEOUT) : 1;
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(ACK_TIMEOUT - 1);

  loader_state_e     state_q;
  logic [ADDR_W-1:0] addr_q;
  logic [31:0]       remaining_q;
  logic [31:0]       data_q;
  logic [WAIT_W-1:0] wait_q;
  logic              ce_q;
  logic              we_q;
  logic              in_ready_q;

  logic              byte_fire;
  logic [31:0]       packed_word;
  logic              word_valid;

  // A byte moves only when the loader advertised ready; abort discards anything in flight.
  assign byte_fire = bus.in_valid && in_ready_q && !abort;

  byte_packer u_packer (
    .clk        (clk),
    .rst        (rst),
    .clear      (abort),
    .byte_en    (byte_fire),
    .byte_in    (bus.in_data),
    .word       (packed_word),
    .word_valid (word_valid)
  );

  assign bus.in_ready   = in_ready_q;
  assign bus.bus_addr_o = 32'(addr_q);
  assign bus.bus_data_o = data_q;
  assign bus.bus_ce_o   = ce_q;
  assign bus.bus_we_o   = we_q;

  // Loader FSM: every output is registered and updated alongside the state transition.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q       <= HDR_ADDR;
      addr_q        <= '0;
      remaining_q   <= '0;
      data_q        <= '0;
      wait_q        <= '0;
      ce_q          <= 1'b0;
      we_q          <= 1'b0;
      in_ready_q    <= 1'b0;
      busy          <= 1'b0;
      done          <= 1'b0;
      error         <= 1'b0;
      words_written <= '0;
    end else if (abort) begin
      state_q       <= HDR_ADDR;
      addr_q        <= '0;
      wait_q        <= '0;
      ce_q          <= 1'b0;
      we_q          <= 1'b0;
      in_ready_q    <= 1'b1;
      busy          <= 1'b0;
      done          <= 1'b0;
      error         <= 1'b0;
      words_written <= '0;
    end else begin
      case (state_q)
        HDR_ADDR: begin
          in_ready_q <= 1'b1;
          if (byte_fire) begin
            busy <= 1'b1;
          end
          if (word_valid) begin
            addr_q  <= packed_word[ADDR_W-1:0];
            state_q <= HDR_CNT;
          end
        end

        HDR_CNT: begin
          if (word_valid) begin
            remaining_q <= packed_word;
            if (packed_word == 32'd0) begin
              state_q <= DONE;
              done    <= 1'b1;
              busy    <= 1'b0;
            end else begin
              state_q <= PAYLOAD;
            end
          end
        end

        PAYLOAD: begin
          if (word_valid) begin
            data_q     <= packed_word;
            ce_q       <= 1'b1;
            we_q       <= 1'b1;
            in_ready_q <= 1'b0;
            wait_q     <= '0;
            state_q    <= WRITE;
          end
        end

        WRITE: begin
          if (bus.bus_ack_i) begin
            ce_q          <= 1'b0;
            we_q          <= 1'b0;
            in_ready_q    <= 1'b1;
            addr_q        <= addr_q + ADDR_W'(1);
            remaining_q   <= remaining_q - 32'd1;
            words_written <= words_written + 32'd1;
            if (remaining_q == 32'd1) begin
              state_q <= DONE;
              done    <= 1'b1;
              busy    <= 1'b0;
            end else begin
              state_q <= PAYLOAD;
            end
          end else if (wait_q == WAIT_LAST) begin
            ce_q    <= 1'b0;
            we_q    <= 1'b0;
            error   <= 1'b1;
            busy    <= 1'b0;
            state_q <= ERROR;
          end else begin
            wait_q <= wait_q + 1'b1;
          end
        end

        DONE: begin
          if (byte_fire) begin
            done          <= 1'b0;
            words_written <= '0;
            busy          <= 1'b1;
            state_q       <= HDR_ADDR;
          end
        end

        ERROR: begin
          in_ready_q <= 1'b0;
        end

        default: begin
          state_q <= HDR_ADDR;
        end
      endcase
    end
  end

endmodule
